// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns pipeline load/store requests into single
// data-bus transactions, with byte-lane steering, load extension and an ack timeout.
module mem_access_unit #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        load_signed,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        stall,
  output logic [31:0] rdata_out,
  output logic        rdata_valid,
  output logic        acc_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYC - 1);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [1:0]  lat_lane;
  logic [1:0]  lat_size;
  logic        lat_signed;
  logic        acc_err_q;

  logic        request, illegal, accept;
  logic [3:0]  be_calc;
  logic [31:0] wd_calc;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext_data;

  assign request = mem_read | mem_write;

  always_comb begin
    illegal = (mem_read & mem_write) || (mem_size == 2'b11) ||
              (mem_size == 2'b01 && mem_addr[0]) ||
              (mem_size == 2'b10 && mem_addr[1:0] != 2'b00);
  end

  assign accept  = (state == IDLE) && request && !illegal && !rst;
  // Illegal requests are rejected in the same cycle; timeouts report from DONE.
  assign stall   = !rst && (accept || state == REQ);
  assign acc_err = acc_err_q || (!rst && state == IDLE && request && illegal);

  always_comb begin
    be_calc = 4'b1111;
    wd_calc = mem_wdata;
    case (mem_size)
      2'b00: begin
        be_calc = 4'b0001 << mem_addr[1:0];
        wd_calc = {4{mem_wdata[7:0]}};
      end
      2'b01: begin
        be_calc = mem_addr[1] ? 4'b1100 : 4'b0011;
        wd_calc = {2{mem_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (lat_lane)
      2'd0:    byte_sel = bus_rdata[7:0];
      2'd1:    byte_sel = bus_rdata[15:8];
      2'd2:    byte_sel = bus_rdata[23:16];
      default: byte_sel = bus_rdata[31:24];
    endcase
    half_sel = lat_lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (lat_size)
      2'b00:   ext_data = {{24{lat_signed & byte_sel[7]}}, byte_sel};
      2'b01:   ext_data = {{16{lat_signed & half_sel[15]}}, half_sel};
      default: ext_data = bus_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      lat_lane    <= '0;
      lat_size    <= '0;
      lat_signed  <= 1'b0;
      acc_err_q   <= 1'b0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_be      <= '0;
      bus_wdata   <= '0;
      rdata_out   <= '0;
      rdata_valid <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      acc_err_q   <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          state      <= REQ;
          wait_cnt   <= '0;
          bus_req    <= 1'b1;
          bus_we     <= mem_write;
          bus_addr   <= {mem_addr[31:2], 2'b00};
          bus_be     <= be_calc;
          bus_wdata  <= wd_calc;
          lat_lane   <= mem_addr[1:0];
          lat_size   <= mem_size;
          lat_signed <= load_signed;
        end
        REQ: begin
          // An ack on the final wait cycle still completes the access.
          if (bus_ack) begin
            state   <= DONE;
            bus_req <= 1'b0;
            if (!bus_we) begin
              rdata_out   <= ext_data;
              rdata_valid <= 1'b1;
            end
          end else if (wait_cnt == LAST_WAIT) begin
            state     <= DONE;
            bus_req   <= 1'b0;
            acc_err_q <= 1'b1;
            rdata_out <= '0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: load results are scoreboarded through a queue,
// stall/valid/error strobes are counted per access and compared against expectations.
module tb_mem_access_unit;
  localparam int TMO = 4;

  logic        clk = 0;
  logic        rst, mem_read, mem_write, load_signed, bus_ack;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, bus_rdata;
  logic        stall, rdata_valid, acc_err, bus_req, bus_we;
  logic [31:0] rdata_out, bus_addr, bus_wdata;
  logic [3:0]  bus_be;

  int n_chk = 0, n_fail = 0;
  int stall_cnt = 0, rv_cnt = 0, err_cnt = 0, txn_cnt = 0;
  logic [31:0] exp_q[$];

  mem_access_unit #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_size(mem_size), .load_signed(load_signed), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .stall(stall), .rdata_out(rdata_out),
    .rdata_valid(rdata_valid), .acc_err(acc_err), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Strobe counters and scoreboard pop, sampled mid-cycle.
  always @(negedge clk) begin
    if (stall) stall_cnt++;
    if (acc_err) err_cnt++;
    if (bus_req && bus_ack) txn_cnt++;
    if (rdata_valid) begin
      rv_cnt++;
      if (exp_q.size() == 0) chk("rv_unexpected", 32'd1, 32'd0);
      else chk("rdata_out", rdata_out, exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    stall_cnt = 0; rv_cnt = 0; err_cnt = 0; txn_cnt = 0;
  endtask

  task automatic idle_in();
    mem_read = 0; mem_write = 0; mem_size = 0; load_signed = 0;
    mem_addr = 0; mem_wdata = 0;
  endtask

  // Called in an IDLE cycle; returns in the following IDLE cycle with inputs idle.
  task automatic access(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic sgn, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] brd, input int nreq, input logic ack,
                        input logic [3:0] ebe, input logic [31:0] ewd);
    mem_read = rd; mem_write = wr; mem_size = sz; load_signed = sgn;
    mem_addr = a; mem_wdata = wd;
    #1 chk("accept_stall", stall, 1'b1);
    step();
    for (int i = 0; i < nreq; i++) begin
      chk("bus_req", bus_req, 1'b1);
      chk("bus_addr", bus_addr, {a[31:2], 2'b00});
      chk("bus_be", bus_be, ebe);
      chk("bus_we", bus_we, wr);
      if (wr) chk("bus_wdata", bus_wdata, ewd);
      if (ack && i == nreq - 1) begin bus_ack = 1; bus_rdata = brd; end
      step();
      bus_ack = 0; bus_rdata = 32'hDEAD_BEEF;
    end
    chk("done_req", bus_req, 1'b0);
    chk("done_stall", stall, 1'b0);
    if (!ack) begin
      chk("to_err", acc_err, 1'b1);
      chk("to_rdata", rdata_out, 32'h0);
    end
    step();
    idle_in();
  endtask

  task automatic illegal(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic [31:0] a);
    clr();
    mem_read = rd; mem_write = wr; mem_size = sz; mem_addr = a;
    #1;
    chk("ill_err", acc_err, 1'b1);
    chk("ill_stall", stall, 1'b0);
    step();
    idle_in();
    #1;
    chk("ill_req", bus_req, 1'b0);
    chk("ill_err_cnt", err_cnt, 1);
    chk("ill_stall_cnt", stall_cnt, 0);
  endtask

  initial begin
    rst = 1; bus_ack = 0; bus_rdata = 0;
    idle_in();
    step(); step();
    chk("rst_stall", stall, 1'b0);
    chk("rst_req", bus_req, 1'b0);
    chk("rst_be", bus_be, 4'h0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_rdata", rdata_out, 32'h0);
    chk("rst_rv", rdata_valid, 1'b0);
    chk("rst_err", acc_err, 1'b0);
    rst = 0;
    step();

    // lb 0x1003 signed, zero wait
    clr(); exp_q.push_back(32'hFFFF_FF80);
    access(1, 0, 2'b00, 1, 32'h1003, 0, 32'h8011_2233, 1, 1, 4'b1000, 0);
    chk("lb_stall", stall_cnt, 2); chk("lb_rv", rv_cnt, 1); chk("lb_err", err_cnt, 0);

    // sh 0x2002, ack on the last allowed wait cycle
    clr();
    access(0, 1, 2'b01, 0, 32'h2002, 32'h0000_BEEF, 0, TMO, 1, 4'b1100, 32'hBEEF_BEEF);
    chk("sh_stall", stall_cnt, 5); chk("sh_rv", rv_cnt, 0); chk("sh_err", err_cnt, 0);

    // sb 0x41
    clr();
    access(0, 1, 2'b00, 0, 32'h41, 32'h1234_56A5, 0, 2, 1, 4'b0010, 32'hA5A5_A5A5);
    chk("sb_stall", stall_cnt, 3); chk("sb_err", err_cnt, 0);

    // lh signed at 0x22
    clr(); exp_q.push_back(32'hFFFF_8001);
    access(1, 0, 2'b01, 1, 32'h22, 0, 32'h8001_7FFF, 1, 1, 4'b1100, 0);
    chk("lh_rv", rv_cnt, 1);

    // lbu at 0x2, zero-extend
    clr(); exp_q.push_back(32'h0000_00C3);
    access(1, 0, 2'b00, 0, 32'h2, 0, 32'h11C3_2233, 1, 1, 4'b0100, 0);
    chk("lbu_rv", rv_cnt, 1);

    // illegal accesses
    illegal(1, 0, 2'b10, 32'h3001);
    illegal(1, 0, 2'b01, 32'h2001);
    illegal(1, 0, 2'b11, 32'h0);
    illegal(1, 1, 2'b10, 32'h0);

    // lh 0x0 timeout
    clr();
    access(1, 0, 2'b01, 1, 32'h0, 0, 0, TMO, 0, 4'b0011, 0);
    chk("to_stall", stall_cnt, 5); chk("to_rv", rv_cnt, 0); chk("to_errc", err_cnt, 1);
    chk("to_txn", txn_cnt, 0);

    // back-to-back lhu 0x10 then sw 0x14
    clr(); exp_q.push_back(32'h0000_F00D);
    access(1, 0, 2'b01, 0, 32'h10, 0, 32'h1234_F00D, 1, 1, 4'b0011, 0);
    access(0, 1, 2'b10, 0, 32'h14, 32'hCAFE_F00D, 0, 1, 1, 4'b1111, 32'hCAFE_F00D);
    chk("b2b_stall", stall_cnt, 4); chk("b2b_txn", txn_cnt, 2); chk("b2b_rv", rv_cnt, 1);

    // reset in the 2nd REQ cycle, late ack afterwards
    clr();
    mem_read = 1; mem_size = 2'b10; mem_addr = 32'h40;
    step(); step();
    rst = 1;
    #1 chk("rst_mid_stall", stall, 1'b0);
    step();
    rst = 0; idle_in(); bus_ack = 1; bus_rdata = 32'h5555_5555;
    #1;
    chk("rm_req", bus_req, 1'b0);
    chk("rm_be", bus_be, 4'h0);
    chk("rm_addr", bus_addr, 32'h0);
    chk("rm_wdata", bus_wdata, 32'h0);
    chk("rm_rdata", rdata_out, 32'h0);
    step();
    bus_ack = 0;
    step();
    chk("rm_req2", bus_req, 1'b0);
    chk("rm_rv", rv_cnt, 0); chk("rm_err", err_cnt, 0); chk("rm_stall", stall_cnt, 2);

    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16: bus_ack wait limit in cycles, legal range 2..255.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 mem_read  in  1  MEM-stage load request, from the control decoder MemRead.
REQ-005 mem_write  in  1  MEM-stage store request, from the control decoder MemWrite.
REQ-006 mem_size  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-007 load_signed  in  1  1 = sign-extend sub-word load; 0 = zero-extend (lbu/lhu).
REQ-008 mem_addr  in  32  byte address.
REQ-009 mem_wdata  in  32  store data, right-aligned.
REQ-010 stall  out  1  freeze pipeline stages up to and including MEM.
REQ-011 rdata_out  out  32  extended load result.
REQ-012 rdata_valid  out  1  one-cycle strobe qualifying rdata_out.
REQ-013 acc_err  out  1  one-cycle strobe: misaligned, illegal or timed-out access.
REQ-014 bus_req, bus_we  out  1 each  data-bus request and write enable.
REQ-015 bus_addr  out  32  word-aligned address, {mem_addr[31:2],2'b00}.
REQ-016 bus_be  out  4  byte enables, bit i = byte lane i (little-endian).
REQ-017 bus_wdata  out  32  lane-replicated store data.
REQ-018 bus_ack  in  1  single-cycle completion from the bus; bus_rdata  in  32  read data, valid with bus_ack.

Function
REQ-019 FSM states IDLE, REQ, DONE; exactly one active.
REQ-020 IDLE, request = mem_read|mem_write: legal access -> latch addr/size/signed/wdata/direction and go to REQ; stall=1 combinationally in that same cycle.
REQ-021 Illegal access in IDLE: mem_read&mem_write both 1, mem_size=11, half with addr[0]=1, or word with addr[1:0]!=0 -> acc_err=1 for that cycle, no bus transaction, stall=0, stay IDLE.
REQ-022 REQ: bus_req=1, stall=1; bus_addr/bus_be/bus_we/bus_wdata are driven from the latched values and held stable until the ack or timeout cycle.
REQ-023 Byte lanes: byte -> bus_be=4'b0001<<addr[1:0], bus_wdata={4{wdata[7:0]}}; half -> bus_be=addr[1]?1100:0011, bus_wdata={2{wdata[15:0]}}; word -> bus_be=1111, bus_wdata=wdata; on reads bus_be carries the same pattern.
REQ-024 bus_ack in REQ -> next state DONE; on reads the selected lane is extracted and extended per load_signed, then registered into rdata_out.
REQ-025 Wait counter: cleared on entry to REQ, +1 each REQ cycle without ack; when count reaches TIMEOUT_CYC-1 with no ack -> bus_req drops next cycle, acc_err=1 for one cycle, rdata_out=0, go to DONE.
REQ-026 bus_ack arriving in the same cycle the timeout would fire: ack wins, no acc_err.
REQ-027 DONE: stall=0, bus_req=0; rdata_valid=1 only for a successful read; request inputs are ignored (they still show the completed instruction); next state IDLE unconditionally.
REQ-028 Access latency: 1 accept cycle + wait cycles + 1 DONE cycle; a zero-wait ack (ack in first REQ cycle) stalls the pipeline exactly 2 cycles.
REQ-029 bus_ack outside REQ is ignored.

Reset
REQ-030 rst=1 at an edge: state=IDLE, counter=0, bus_req=bus_we=0, bus_be=0, bus_addr=bus_wdata=0, rdata_out=0, rdata_valid=acc_err=0; stall=0 while rst=1.
REQ-031 rst during REQ aborts the access: bus_req is 0 after that edge; a late bus_ack is then ignored per REQ-029.

Verification
REQ-032 Load byte, addr=0x1003, load_signed=1, bus_rdata=0x80112233, ack in 1st REQ cycle -> bus_be=1000, rdata_out=0xFFFFFF80, rdata_valid 1 cycle, stall 2 cycles.
REQ-033 Store half, addr=0x2002, wdata=0x0000BEEF, ack after 3 wait cycles -> bus_we=1, bus_be=1100, bus_wdata=0xBEEFBEEF, stable 4 cycles, no rdata_valid.
REQ-034 Load word at addr=0x3001 -> acc_err for 1 cycle, bus_req never asserts, stall=0.
REQ-035 Load half, addr=0x0, TIMEOUT_CYC=4, no ack -> bus_req high 4 cycles, acc_err=1, rdata_out=0, rdata_valid=0, return to IDLE.
REQ-036 rst asserted in 2nd REQ cycle, bus_ack the following cycle -> all outputs at reset values, no rdata_valid, no acc_err.
REQ-037 Back-to-back lhu at 0x10 then sw at 0x14, zero-wait -> two distinct bus transactions, DONE between them, total stall 4 cycles.
